// File: rtl/ddiff_sched_if.sv
// Channel-side bus of the shared delayed-difference scheduler: requests, samples,
// clears and order in; one-hot grant and the registered difference result out.
interface ddiff_sched_if #(
  parameter int NCH = 4,
  parameter int W   = 16
);
  logic [NCH-1:0]   req;
  logic [NCH*W-1:0] sample;
  logic [NCH-1:0]   grant;
  logic [NCH-1:0]   clr;
  logic [1:0]       order;
  logic             out_valid;
  logic [2:0]       out_ch;
  logic [W-1:0]     out_mag;
  logic             out_sign;
  logic             out_prime;

  modport master (
    output req, sample, clr, order,
    input  grant, out_valid, out_ch, out_mag, out_sign, out_prime
  );

  modport slave (
    input  req, sample, clr, order,
    output grant, out_valid, out_ch, out_mag, out_sign, out_prime
  );
endinterface

// File: rtl/ddiff_sched.sv
// Round-robin time-shared 1st/2nd/3rd order delayed-difference chain, per-channel history.
// Build option: define DDIFF_SAT_EN to saturate magnitudes; otherwise they wrap.
module ddiff_sched #(
  parameter int NCH = 4,
  parameter int W   = 16
) (
  input logic        clk,
  input logic        rst,
  ddiff_sched_if.slave bus
);
`ifdef DDIFF_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef logic [W:0] sm_t;  // {sign, magnitude}

  // Sign-magnitude a - b through W+2-bit two's complement; -0 folds to +0.
  function automatic sm_t sm_sub(input sm_t a, input sm_t b);
    logic [W+1:0] va;
    logic [W+1:0] vb;
    logic [W+1:0] diff;
    logic [W+1:0] abs_v;
    logic         neg;
    logic         ovf;
    logic [W-1:0] mag;
    va = {2'b00, a[W-1:0]};
    if (a[W]) va = -va;
    vb = {2'b00, b[W-1:0]};
    if (b[W]) vb = -vb;
    diff  = va - vb;
    neg   = diff[W+1];
    abs_v = neg ? -diff : diff;
    ovf   = |abs_v[W+1:W];
    mag   = (SAT_EN && ovf) ? {W{1'b1}} : abs_v[W-1:0];
    return {neg & (|mag), mag};
  endfunction

  // Arbiter
  logic [2:0]     ptr_reg;
  logic [2:0]     ptr_next;
  logic [2:0]     gnt_idx;
  logic           gnt_found;
  logic [NCH-1:0] grant_vec;
  logic [NCH-1:0] req_hi;
  logic [NCH-1:0] pick;
  logic [W-1:0]   gnt_sample;

  always_comb begin
    req_hi     = '0;
    gnt_idx    = '0;
    grant_vec  = '0;
    gnt_sample = '0;
    for (int c = 0; c < NCH; c++) begin
      req_hi[c] = bus.req[c] && (3'(c) >= ptr_reg);
    end
    // Requests at or above the pointer win; otherwise wrap to the lowest request.
    pick      = (|req_hi) ? req_hi : bus.req;
    gnt_found = (|pick) && !rst;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (pick[c]) gnt_idx = 3'(c);
    end
    for (int c = 0; c < NCH; c++) begin
      grant_vec[c] = gnt_found && (gnt_idx == 3'(c));
      if (grant_vec[c]) gnt_sample = bus.sample[c*W +: W];
    end
    ptr_next = (gnt_idx == 3'(NCH - 1)) ? 3'd0 : gnt_idx + 3'd1;
  end

  assign bus.grant = grant_vec;

  // Stage A: capture the granted sample with its effective order
  logic         a_valid_reg;
  logic [2:0]   a_ch_reg;
  logic [W-1:0] a_x_reg;
  logic [1:0]   a_order_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg     <= '0;
      a_valid_reg <= 1'b0;
      a_ch_reg    <= '0;
      a_x_reg     <= '0;
      a_order_reg <= 2'd1;
    end else begin
      a_valid_reg <= gnt_found;
      if (gnt_found) begin
        ptr_reg     <= ptr_next;
        a_ch_reg    <= gnt_idx;
        a_x_reg     <= gnt_sample;
        a_order_reg <= (bus.order == 2'd0) ? 2'd1 : bus.order;
      end
    end
  end

  // Per-channel history
  logic [W-1:0] x1_reg  [NCH];
  sm_t          d1p_reg [NCH];
  sm_t          d2p_reg [NCH];
  logic [1:0]   cnt_reg [NCH];

  logic [W-1:0] x1_sel;
  sm_t          d1p_sel;
  sm_t          d2p_sel;
  logic [1:0]   cnt_sel;
  sm_t          d1;
  sm_t          d2;
  sm_t          d3;
  sm_t          res_sel;
  logic         prime_sel;

  always_comb begin
    x1_sel  = '0;
    d1p_sel = '0;
    d2p_sel = '0;
    cnt_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      if (a_ch_reg == 3'(c)) begin
        x1_sel  = x1_reg[c];
        d1p_sel = d1p_reg[c];
        d2p_sel = d2p_reg[c];
        cnt_sel = cnt_reg[c];
      end
    end
    d1 = sm_sub({1'b0, a_x_reg}, {1'b0, x1_sel});
    d2 = sm_sub(d1, d1p_sel);
    d3 = sm_sub(d2, d2p_sel);
    case (a_order_reg)
      2'd2:    res_sel = d2;
      2'd3:    res_sel = d3;
      default: res_sel = d1;
    endcase
    prime_sel = cnt_sel < a_order_reg;
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_hist
    // A clear beats a same-cycle history write for this channel.
    always_ff @(posedge clk) begin
      if (rst || bus.clr[gi]) begin
        x1_reg[gi]  <= '0;
        d1p_reg[gi] <= '0;
        d2p_reg[gi] <= '0;
        cnt_reg[gi] <= '0;
      end else if (a_valid_reg && (a_ch_reg == 3'(gi))) begin
        x1_reg[gi]  <= a_x_reg;
        d1p_reg[gi] <= d1;
        d2p_reg[gi] <= d2;
        cnt_reg[gi] <= (cnt_reg[gi] == 2'd3) ? 2'd3 : cnt_reg[gi] + 2'd1;
      end
    end
  end

  // Stage B result register
  logic         out_valid_reg;
  logic [2:0]   out_ch_reg;
  logic [W-1:0] out_mag_reg;
  logic         out_sign_reg;
  logic         out_prime_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_ch_reg    <= '0;
      out_mag_reg   <= '0;
      out_sign_reg  <= 1'b0;
      out_prime_reg <= 1'b0;
    end else begin
      out_valid_reg <= a_valid_reg;
      if (a_valid_reg) begin
        out_ch_reg    <= a_ch_reg;
        out_mag_reg   <= res_sel[W-1:0];
        out_sign_reg  <= res_sel[W];
        out_prime_reg <= prime_sel;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_ch    = out_ch_reg;
  assign bus.out_mag   = out_mag_reg;
  assign bus.out_sign  = out_sign_reg;
  assign bus.out_prime = out_prime_reg;
endmodule

// File: tb/tb_ddiff_sched.sv
// Directed bench for ddiff_sched: chain values, round-robin order, wraparound,
// overflow, clear and mid-flight reset, each with hand-computed expectations.
module tb_ddiff_sched;
  localparam int NCH = 4;
  localparam int W   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  ddiff_sched_if #(.NCH(NCH), .W(W)) bus ();
  ddiff_sched #(.NCH(NCH), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // ch0 order-3 chain for 100, 150, 120, 200 from zeroed history
  logic [15:0] t1_in [4] = '{16'd100, 16'd150, 16'd120, 16'd200};
  logic        t1_s  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [15:0] t1_m  [4] = '{16'd100, 16'd150, 16'd30, 16'd190};
  logic        t1_p  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

`ifdef DDIFF_SAT_EN
  localparam logic [15:0] OVF_MAG = 16'hFFFF;
`else
  localparam logic [15:0] OVF_MAG = 16'hFFFE;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] res(input int ch, input logic s, input logic [15:0] m, input logic p);
    return {10'b0, 1'b1, 3'(ch), s, m, p};
  endfunction

  function automatic logic [31:0] obs_out();
    return {10'b0, bus.out_valid, bus.out_ch, bus.out_sign, bus.out_mag, bus.out_prime};
  endfunction

  task automatic put(input int ch, input logic [15:0] v);
    bus.req    = 4'(1 << ch);
    bus.sample = {4{v}};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req    = '0;
    bus.clr    = '0;
    bus.order  = 2'd0;
    bus.sample = '0;
    tick;
    tick;
    chk("reset_out", obs_out(), 32'h0);
    chk("reset_grant", 32'(bus.grant), 32'h0);
    rst = 1'b0;

    // order-3 chain on ch0
    bus.order = 2'd3;
    for (int i = 0; i < 4; i++) begin
      put(0, t1_in[i]);
      #1 chk("t1_grant", 32'(bus.grant), 32'h1);
      tick;
      if (i == 0) chk("t1_latency", 32'(bus.out_valid), 32'h0);
      else chk("t1_out", obs_out(), res(0, t1_s[i-1], t1_m[i-1], t1_p[i-1]));
    end
    bus.req = '0;
    tick;
    chk("t1_out_last", obs_out(), res(0, t1_s[3], t1_m[3], t1_p[3]));
    tick;
    chk("t1_idle", 32'(bus.out_valid), 32'h0);

    // round robin with all requesting
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.order = 2'd1;
    for (int i = 0; i < 8; i++) begin
      put(0, 16'(i));
      bus.req = 4'hF;
      #1 chk("rr_grant", 32'(bus.grant), 32'(1 << (i % 4)));
      tick;
      if (i >= 1) chk("rr_out_ch", {28'b0, bus.out_valid, bus.out_ch}, {28'b0, 1'b1, 3'((i - 1) % 4)});
    end
    bus.req = '0;
    tick;
    chk("rr_out_ch_last", {28'b0, bus.out_valid, bus.out_ch}, {28'b0, 1'b1, 3'd3});

    // pointer wraparound: move ptr to 2, then req=0011
    bus.req = 4'b0010;
    #1 chk("wrap_setup", 32'(bus.grant), 32'h2);
    tick;
    bus.req = 4'b0011;
    #1 chk("wrap_grant0", 32'(bus.grant), 32'h1);
    tick;
    #1 chk("wrap_grant1", 32'(bus.grant), 32'h2);
    tick;
    bus.req = '0;
    tick;
    tick;

    // order 1, no overflow at full-scale step
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.order = 2'd1;
    put(1, 16'hFFFF);
    tick;
    put(1, 16'h0000);
    tick;
    chk("o1_first", obs_out(), res(1, 1'b0, 16'hFFFF, 1'b1));
    bus.req = '0;
    tick;
    chk("o1_second", obs_out(), res(1, 1'b1, 16'hFFFF, 1'b0));
    tick;

    // order 2 overflow: d2 = -0x1FFFE
    bus.order = 2'd2;
    bus.clr   = 4'b0010;
    tick;
    bus.clr = '0;
    put(1, 16'h0000);
    tick;
    put(1, 16'hFFFF);
    tick;
    chk("o2_s0", obs_out(), res(1, 1'b0, 16'h0000, 1'b1));
    put(1, 16'h0000);
    tick;
    chk("o2_s1", obs_out(), res(1, 1'b0, 16'hFFFF, 1'b1));
    bus.req = '0;
    tick;
    chk("o2_ovf", obs_out(), res(1, 1'b1, OVF_MAG, 1'b0));
    tick;

    // clr during stage B of a ch2 sample; order 0 acts as 1
    bus.order = 2'd0;
    put(2, 16'd500);
    tick;
    bus.req = '0;
    bus.clr = 4'b0100;
    tick;
    chk("clr_first", obs_out(), res(2, 1'b0, 16'd500, 1'b1));
    bus.clr = '0;
    put(2, 16'd500);
    tick;
    bus.req = '0;
    tick;
    chk("clr_second", obs_out(), res(2, 1'b0, 16'd500, 1'b1));

    // req and clr for ch3 in the same cycle
    put(3, 16'd700);
    tick;
    put(3, 16'd700);
    bus.clr = 4'b1000;
    tick;
    chk("reqclr_first", obs_out(), res(3, 1'b0, 16'd700, 1'b1));
    bus.clr = '0;
    bus.req = '0;
    tick;
    chk("reqclr_second", obs_out(), res(3, 1'b0, 16'd700, 1'b1));

    // reset with a sample in flight
    put(0, 16'd42);
    tick;
    rst     = 1'b1;
    bus.req = '0;
    tick;
    chk("rst_mid_out0", obs_out(), 32'h0);
    rst = 1'b0;
    tick;
    chk("rst_mid_out1", obs_out(), 32'h0);
    tick;
    chk("rst_mid_out2", obs_out(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
